// File: rtl/ascon_output_collector.sv
// Ascon ciphertext/tag collector: FWFT FIFO of {last, word}, up to 3 pushes in, 1 pop out per cycle.
// Latency 1 cycle push-to-head; pushes are atomic and dropped (sticky overflow_o) when they do not fit.
// Optional drained-message counter built only when ASCON_MSG_CNT_EN is defined.
module ascon_output_collector #(
    parameter int DEPTH = 8
) (
    input  logic                       clock_i,
    input  logic                       resetb_i,
    input  logic                       cipher_valid_i,
    input  logic [63:0]                cipher_i,
    input  logic                       end_i,
    input  logic [127:0]               tag_i,
    input  logic                       clear_i,
    output logic [63:0]                dout_o,
    output logic                       dout_valid_o,
    input  logic                       dout_ready_i,
    output logic                       dout_last_o,
    output logic                       space_ok_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic [15:0]                msg_cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [64:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic          pop;
    logic          accept;
    logic [1:0]    push_size;
    logic [1:0]    push_n;
    logic [CW:0]   room;
    logic [64:0]   word [3];

    always_comb begin
        pop       = (count_q != '0) && dout_ready_i;
        push_size = {1'b0, cipher_valid_i} + (end_i ? 2'd2 : 2'd0);
        // The slot freed by a same-cycle pop counts as room for the push.
        room      = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop};
        accept    = ({{(CW-1){1'b0}}, push_size} <= room);
        push_n    = accept ? push_size : 2'd0;
        word[0]   = '0;
        word[1]   = '0;
        word[2]   = '0;
        if (cipher_valid_i) begin
            word[0] = {1'b0, cipher_i};
            word[1] = {1'b0, tag_i[127:64]};
            word[2] = {1'b1, tag_i[63:0]};
        end else begin
            word[0] = {1'b0, tag_i[127:64]};
            word[1] = {1'b1, tag_i[63:0]};
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (k < int'(push_n)) begin
                    mem_q[wr_ptr_q + PW'(k)] <= word[k];
                end
            end
            wr_ptr_q <= wr_ptr_q + PW'(push_n);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            count_q  <= count_q + CW'(push_n) - CW'(pop);
            if (push_size != 2'd0 && !accept) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef ASCON_MSG_CNT_EN
    logic [15:0] msg_cnt_q;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            msg_cnt_q <= '0;
        end else if (clear_i) begin
            msg_cnt_q <= '0;
        end else if (pop && mem_q[rd_ptr_q][64]) begin
            msg_cnt_q <= msg_cnt_q + 16'd1;
        end
    end

    assign msg_cnt_o = msg_cnt_q;
`else
    assign msg_cnt_o = 16'h0000;
`endif

    assign dout_o       = mem_q[rd_ptr_q][63:0];
    assign dout_last_o  = mem_q[rd_ptr_q][64];
    assign dout_valid_o = (count_q != '0);
    assign count_o      = count_q;
    assign space_ok_o   = ({1'b0, count_q} <= (CW+1)'(DEPTH - 5));
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_ascon_output_collector.sv
// Scoreboard bench for ascon_output_collector (DEPTH=8); expected words are queued at stimulus time.
module tb_ascon_output_collector;
    localparam int DEPTH = 8;

    logic          clock_i = 1'b0;
    logic          resetb_i = 1'b0;
    logic          cipher_valid_i = 1'b0;
    logic [63:0]   cipher_i = '0;
    logic          end_i = 1'b0;
    logic [127:0]  tag_i = '0;
    logic          clear_i = 1'b0;
    logic [63:0]   dout_o;
    logic          dout_valid_o;
    logic          dout_ready_i = 1'b0;
    logic          dout_last_o;
    logic          space_ok_o;
    logic [3:0]    count_o;
    logic          overflow_o;
    logic [15:0]   msg_cnt_o;

    int tests = 0;
    int fails = 0;
    int exp_msg = 0;
    logic [64:0] sb_q [$];

    ascon_output_collector #(.DEPTH(DEPTH)) dut (
        .clock_i        (clock_i),
        .resetb_i       (resetb_i),
        .cipher_valid_i (cipher_valid_i),
        .cipher_i       (cipher_i),
        .end_i          (end_i),
        .tag_i          (tag_i),
        .clear_i        (clear_i),
        .dout_o         (dout_o),
        .dout_valid_o   (dout_valid_o),
        .dout_ready_i   (dout_ready_i),
        .dout_last_o    (dout_last_o),
        .space_ok_o     (space_ok_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .msg_cnt_o      (msg_cnt_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_msg_cnt();
`ifdef ASCON_MSG_CNT_EN
        return exp_msg[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    // Monitor: each accepted output word is compared with the scoreboard head.
    always @(negedge clock_i) begin
        if (resetb_i && dout_valid_o && dout_ready_i) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got %h, scoreboard empty", dout_o);
            end else begin
                logic [64:0] e;
                e = sb_q.pop_front();
                check("dout_data", dout_o, e[63:0]);
                check("dout_last", {63'd0, dout_last_o}, {63'd0, e[64]});
                if (e[64]) exp_msg++;
            end
        end
    end

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic push_c(input logic [63:0] d);
        cipher_valid_i = 1'b1;
        cipher_i = d;
        sb_q.push_back({1'b0, d});
        step();
        cipher_valid_i = 1'b0;
    endtask

    task automatic push_t(input logic [127:0] t);
        end_i = 1'b1;
        tag_i = t;
        sb_q.push_back({1'b0, t[127:64]});
        sb_q.push_back({1'b1, t[63:0]});
        step();
        end_i = 1'b0;
    endtask

    task automatic push_msg(input logic [63:0] base);
        push_c(base ^ 64'h1111_1111_1111_1111);
        push_c(base ^ 64'h2222_2222_2222_2222);
        push_c(base ^ 64'h3333_3333_3333_3333);
        push_t({base ^ 64'hAAAA_AAAA_AAAA_AAAA, base ^ 64'hBBBB_BBBB_BBBB_BBBB});
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while ((count_o != 0 || sb_q.size() != 0) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: count %0d, %0d words outstanding", name, count_o, sb_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_valid", {63'd0, dout_valid_o}, 64'd0);
        check("rst_dout", dout_o, 64'd0);
        check("rst_last", {63'd0, dout_last_o}, 64'd0);
        check("rst_count", {60'd0, count_o}, 64'd0);
        check("rst_space_ok", {63'd0, space_ok_o}, 64'd1);
        check("rst_overflow", {63'd0, overflow_o}, 64'd0);
        check("rst_msg_cnt", {48'd0, msg_cnt_o}, 64'd0);
        resetb_i = 1'b1;
        step();

        // Normal message, host always ready.
        dout_ready_i = 1'b1;
        push_msg(64'd0);
        wait_empty("normal");
        check("normal_count", {60'd0, count_o}, 64'd0);
        check("normal_msg_cnt", {48'd0, msg_cnt_o}, {48'd0, exp_msg_cnt()});

        // Backpressure: head holds C1 while the whole message stacks up.
        dout_ready_i = 1'b0;
        push_msg(64'd0);
        check("bp_count", {60'd0, count_o}, 64'd5);
        check("bp_space_ok", {63'd0, space_ok_o}, 64'd0);
        check("bp_head", dout_o, 64'h1111_1111_1111_1111);
        step();
        check("bp_head_stable", dout_o, 64'h1111_1111_1111_1111);
        dout_ready_i = 1'b1;
        repeat (5) step();
        check("bp_drain5", {60'd0, count_o}, 64'd0);

        // Overflow: tag push into 7 occupied entries is dropped whole.
        dout_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) push_c(64'hC0DE_0000_0000_0000 + 64'(i));
        end_i = 1'b1;
        tag_i = {64'hDEAD_DEAD_DEAD_DEAD, 64'hBEEF_BEEF_BEEF_BEEF};
        step();
        end_i = 1'b0;
        check("ovf_flag", {63'd0, overflow_o}, 64'd1);
        check("ovf_count7", {60'd0, count_o}, 64'd7);
        push_c(64'hC0DE_0000_0000_0007);
        check("ovf_count8", {60'd0, count_o}, 64'd8);
        clear_i = 1'b1;
        sb_q.delete();
        exp_msg = 0;
        step();
        clear_i = 1'b0;
        check("clr_count", {60'd0, count_o}, 64'd0);
        check("clr_overflow", {63'd0, overflow_o}, 64'd0);
        check("clr_valid", {63'd0, dout_valid_o}, 64'd0);
        check("clr_msg_cnt", {48'd0, msg_cnt_o}, 64'd0);

        // Simultaneous cipher + tag with a pop at count 1.
        push_c(64'h5555_0000_0000_0001);
        dout_ready_i = 1'b1;
        cipher_valid_i = 1'b1;
        cipher_i = 64'h5555_0000_0000_0002;
        end_i = 1'b1;
        tag_i = {64'h5555_0000_0000_00A0, 64'h5555_0000_0000_00B0};
        sb_q.push_back({1'b0, 64'h5555_0000_0000_0002});
        sb_q.push_back({1'b0, 64'h5555_0000_0000_00A0});
        sb_q.push_back({1'b1, 64'h5555_0000_0000_00B0});
        step();
        cipher_valid_i = 1'b0;
        end_i = 1'b0;
        dout_ready_i = 1'b0;
        check("sim_count3", {60'd0, count_o}, 64'd3);
        dout_ready_i = 1'b1;
        wait_empty("simul");

        // Three back-to-back messages wrap the pointers.
        exp_msg = 0;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        push_msg(64'h0100_0000_0000_0000);
        push_msg(64'h0200_0000_0000_0000);
        push_msg(64'h0300_0000_0000_0000);
        wait_empty("wrap");
        check("wrap_msg_cnt", {48'd0, msg_cnt_o}, {48'd0, exp_msg_cnt()});

        // Asynchronous reset in the middle of a drain.
        dout_ready_i = 1'b0;
        push_msg(64'h0400_0000_0000_0000);
        dout_ready_i = 1'b1;
        step();
        step();
        #2;
        resetb_i = 1'b0;
        sb_q.delete();
        exp_msg = 0;
        #1;
        check("arst_valid", {63'd0, dout_valid_o}, 64'd0);
        check("arst_dout", dout_o, 64'd0);
        check("arst_last", {63'd0, dout_last_o}, 64'd0);
        check("arst_count", {60'd0, count_o}, 64'd0);
        check("arst_space_ok", {63'd0, space_ok_o}, 64'd1);
        check("arst_msg_cnt", {48'd0, msg_cnt_o}, 64'd0);
        step();
        resetb_i = 1'b1;
        repeat (4) step();
        check("post_rst_valid", {63'd0, dout_valid_o}, 64'd0);
        check("post_rst_count", {60'd0, count_o}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
